// File: rtl/rams_tdp_pkg.sv
// Shared definitions for the true-dual-port RAM.
//   RDW_*        read-during-write mode encodings for MODE_A / MODE_B
//   state_t      zero-fill sweep FSM states
//   merge_lanes  overlays the written byte lanes of a new word onto an old one
package rams_tdp_pkg;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;
   localparam int RDW_NO_CHANGE   = 2;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   // Widest word the merge helper handles; callers zero-extend into it and
   // truncate the result back to their own width.
   localparam int MERGE_MAX = 256;

   function automatic logic [MERGE_MAX-1:0] merge_lanes(
      input logic [MERGE_MAX-1:0] old_word,
      input logic [MERGE_MAX-1:0] new_word,
      input logic [MERGE_MAX-1:0] we,
      input int                   bw
   );
      logic [MERGE_MAX-1:0] res;
      res = old_word;
      for (int b = 0; b < MERGE_MAX; b++) begin
         if (we[b / bw]) res[b] = new_word[b];
      end
      return res;
   endfunction

endpackage

// File: rtl/rams_tdp_port_out.sv
// Read-data path for one RAM port: read-during-write mode selection, output
// hold and the optional second register stage.
//   clk, rst    clock / async active-high reset
//   en          port accepted this cycle (enable and RAM ready)
//   we_any      any write lane set on this port
//   rd_old      stored word before this cycle's writes
//   rd_merged   stored word with this port's written lanes overlaid
//   dout        port read data
module rams_tdp_port_out
   import rams_tdp_pkg::*;
#(
   parameter int DW   = 16,
   parameter int MODE = RDW_READ_FIRST,
   parameter int OREG = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          we_any,
   input  logic [DW-1:0] rd_old,
   input  logic [DW-1:0] rd_merged,
   output logic [DW-1:0] dout
);

   logic          ld1;
   logic [DW-1:0] d1;
   logic [DW-1:0] q1;

   // No-change ports keep their output on any write cycle.
   assign ld1 = en && !((MODE == RDW_NO_CHANGE) && we_any);
   assign d1  = (MODE == RDW_WRITE_FIRST) ? rd_merged : rd_old;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q1 <= '0;
      else if (ld1) q1 <= d1;
   end

   if (OREG != 0) begin : g_oreg
      logic          ld1_q;
      logic [DW-1:0] q2;

      // Second stage follows the first only when the first actually loaded.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            ld1_q <= 1'b0;
            q2    <= '0;
         end else begin
            ld1_q <= ld1;
            if (ld1_q) q2 <= q1;
         end
      end
      assign dout = q2;
   end else begin : g_noreg
      assign dout = q1;
   end

endmodule

// File: rtl/rams_tdp_param_bwe.sv
// Parametrised true-dual-port RAM with per-byte write enables, per-port
// read-during-write mode, optional output register and post-reset zero fill.
//   clk, rst          single clock / async active-high reset
//   ena, enb          port enables
//   wea, web          per-lane write enables (NBE = DW/BW)
//   addra, addrb      word addresses
//   dia, dib          write data
//   doa, dob          read data (latency 1+OREG)
//   busy              zero-fill sweep running
//   collision         pulse: both ports wrote the same address
//
// state    | meaning
// ST_CLEAR | zero-fill sweep, one address per cycle, ports ignored
// ST_READY | normal dual-port operation
module rams_tdp_param_bwe
   import rams_tdp_pkg::*;
#(
   parameter int DW           = 16,
   parameter int BW           = 8,
   parameter int AW           = 10,
   parameter int MODE_A       = RDW_READ_FIRST,
   parameter int MODE_B       = RDW_READ_FIRST,
   parameter int OREG         = 0,
   parameter int CLEAR_ON_RST = 1,
   localparam int NBE         = DW / BW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ena,
   input  logic           enb,
   input  logic [NBE-1:0] wea,
   input  logic [NBE-1:0] web,
   input  logic [AW-1:0]  addra,
   input  logic [AW-1:0]  addrb,
   input  logic [DW-1:0]  dia,
   input  logic [DW-1:0]  dib,
   output logic [DW-1:0]  doa,
   output logic [DW-1:0]  dob,
   output logic           busy,
   output logic           collision
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem [0:DEPTH-1];

   state_t        state;
   logic [AW-1:0] clr_rem;
   logic [AW-1:0] clr_addr;
   logic          ready;
   logic [DW-1:0] rd_a, rd_b;
   logic [DW-1:0] mrg_a, mrg_b;

   assign ready    = (state == ST_READY);
   assign busy     = (state == ST_CLEAR);
   // Remaining-count runs down to zero; its complement walks 0 .. DEPTH-1.
   assign clr_addr = ~clr_rem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
         clr_rem   <= '1;
         collision <= 1'b0;
      end else begin
         if (state == ST_CLEAR) begin
            clr_rem <= clr_rem - 1'b1;
            if (clr_rem == '0) state <= ST_READY;
         end
         collision <= ready && ena && enb && (addra == addrb) && (|wea) && (|web);
      end
   end

   // Port A lanes are written after port B lanes so A wins shared lanes.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         mem[clr_addr] <= '0;
      end else begin
         for (int i = 0; i < NBE; i++) begin
            if (enb && web[i]) mem[addrb][i*BW +: BW] <= dib[i*BW +: BW];
            if (ena && wea[i]) mem[addra][i*BW +: BW] <= dia[i*BW +: BW];
         end
      end
   end

   assign rd_a  = mem[addra];
   assign rd_b  = mem[addrb];
   assign mrg_a = DW'(merge_lanes(MERGE_MAX'(rd_a), MERGE_MAX'(dia), MERGE_MAX'(wea), BW));
   assign mrg_b = DW'(merge_lanes(MERGE_MAX'(rd_b), MERGE_MAX'(dib), MERGE_MAX'(web), BW));

   rams_tdp_port_out #(.DW(DW), .MODE(MODE_A), .OREG(OREG)) u_out_a (
      .clk       (clk),
      .rst       (rst),
      .en        (ena && ready),
      .we_any    (|wea),
      .rd_old    (rd_a),
      .rd_merged (mrg_a),
      .dout      (doa)
   );

   rams_tdp_port_out #(.DW(DW), .MODE(MODE_B), .OREG(OREG)) u_out_b (
      .clk       (clk),
      .rst       (rst),
      .en        (enb && ready),
      .we_any    (|web),
      .rd_old    (rd_b),
      .rd_merged (mrg_b),
      .dout      (dob)
   );

endmodule

// File: tb/tb_rams_tdp_param_bwe.sv
// Two RAM instances (AW=4):
//   u_ram0: MODE_A write-first, MODE_B read-first, no output register
//   u_ram1: MODE_A read-first,  MODE_B no-change,  output register
module tb_rams_tdp_param_bwe;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena [2];
   logic        enb [2];
   logic [1:0]  wea [2];
   logic [1:0]  web [2];
   logic [3:0]  addra [2];
   logic [3:0]  addrb [2];
   logic [15:0] dia [2];
   logic [15:0] dib [2];
   logic [15:0] doa [2];
   logic [15:0] dob [2];
   logic        busy [2];
   logic        collision [2];

   always #5 clk = ~clk;

   rams_tdp_param_bwe #(.DW(16), .BW(8), .AW(4), .MODE_A(1), .MODE_B(0),
                        .OREG(0), .CLEAR_ON_RST(1)) u_ram0 (
      .clk(clk), .rst(rst), .ena(ena[0]), .enb(enb[0]), .wea(wea[0]), .web(web[0]),
      .addra(addra[0]), .addrb(addrb[0]), .dia(dia[0]), .dib(dib[0]),
      .doa(doa[0]), .dob(dob[0]), .busy(busy[0]), .collision(collision[0]));

   rams_tdp_param_bwe #(.DW(16), .BW(8), .AW(4), .MODE_A(0), .MODE_B(2),
                        .OREG(1), .CLEAR_ON_RST(1)) u_ram1 (
      .clk(clk), .rst(rst), .ena(ena[1]), .enb(enb[1]), .wea(wea[1]), .web(web[1]),
      .addra(addra[1]), .addrb(addrb[1]), .dia(dia[1]), .dib(dib[1]),
      .doa(doa[1]), .dob(dob[1]), .busy(busy[1]), .collision(collision[1]));

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      int          due;
      int          sig;
      logic [15:0] exp;
   } sb_t;
   sb_t sbq [$];

   // Reference model state per instance / port
   logic [15:0] mmem [2][16];
   logic [15:0] q1 [2][2];
   logic [15:0] q2 [2][2];
   logic        ldp [2][2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int port_mode(input int j, input int p);
      if (j == 0) return (p == 0) ? 1 : 0;
      return (p == 0) ? 0 : 2;
   endfunction

   function automatic bit has_oreg(input int j);
      return j == 1;
   endfunction

   function automatic logic [15:0] mrg(input logic [15:0] o, input logic [15:0] n, input logic [1:0] w);
      logic [15:0] r;
      r = o;
      if (w[0]) r[7:0]  = n[7:0];
      if (w[1]) r[15:8] = n[15:8];
      return r;
   endfunction

   function automatic logic [15:0] observe(input int sig);
      case (sig)
         0: return doa[0];
         1: return dob[0];
         2: return {15'd0, collision[0]};
         3: return {15'd0, busy[0]};
         4: return doa[1];
         5: return dob[1];
         6: return {15'd0, collision[1]};
         default: return {15'd0, busy[1]};
      endcase
   endfunction

   function automatic string sig_name(input int sig);
      case (sig)
         0: return "ram0_doa";
         1: return "ram0_dob";
         2: return "ram0_collision";
         3: return "ram0_busy";
         4: return "ram1_doa";
         5: return "ram1_dob";
         6: return "ram1_collision";
         default: return "ram1_busy";
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int k = sbq.size() - 1; k >= 0; k--) begin
         if (sbq[k].due == cyc) begin
            chk(sig_name(sbq[k].sig), 32'(observe(sbq[k].sig)), 32'(sbq[k].exp));
            sbq.delete(k);
         end
      end
   end

   task automatic reset_model();
      for (int j = 0; j < 2; j++) begin
         for (int a = 0; a < 16; a++) mmem[j][a] = 16'h0000;
         for (int p = 0; p < 2; p++) begin
            q1[j][p]  = 16'h0000;
            q2[j][p]  = 16'h0000;
            ldp[j][p] = 1'b0;
         end
      end
   endtask

   task automatic model_step(input int j,
                             input logic ea, input logic [1:0] wa, input logic [3:0] aa, input logic [15:0] da,
                             input logic eb, input logic [1:0] wb, input logic [3:0] ab, input logic [15:0] db);
      logic [15:0] old_w, din, v;
      logic [1:0]  w;
      logic        en, ld;
      int          md;
      for (int p = 0; p < 2; p++) begin
         en    = (p == 0) ? ea : eb;
         w     = (p == 0) ? wa : wb;
         din   = (p == 0) ? da : db;
         old_w = mmem[j][(p == 0) ? aa : ab];
         md    = port_mode(j, p);
         ld    = en && !(md == 2 && (|w));
         v     = (md == 1) ? mrg(old_w, din, w) : old_w;
         if (ldp[j][p]) q2[j][p] = q1[j][p];
         if (ld) q1[j][p] = v;
         ldp[j][p] = ld;
         sbq.push_back('{cyc + 1, j*4 + p, has_oreg(j) ? q2[j][p] : q1[j][p]});
      end
      sbq.push_back('{cyc + 1, j*4 + 2, {15'd0, ea && eb && (aa == ab) && (|wa) && (|wb)}});
      sbq.push_back('{cyc + 1, j*4 + 3, 16'h0000});
      for (int l = 0; l < 2; l++) begin
         if (eb && wb[l]) mmem[j][ab][l*8 +: 8] = db[l*8 +: 8];
      end
      for (int l = 0; l < 2; l++) begin
         if (ea && wa[l]) mmem[j][aa][l*8 +: 8] = da[l*8 +: 8];
      end
   endtask

   // One clock cycle of traffic on instance i; the other instance idles.
   task automatic drive(input int i, input int ea, input int wa, input int aa, input int da,
                        input int eb, input int wb, input int ab, input int db);
      for (int j = 0; j < 2; j++) begin
         ena[j]   = (j == i) ? ea[0]    : 1'b0;
         wea[j]   = (j == i) ? wa[1:0]  : 2'b00;
         addra[j] = (j == i) ? aa[3:0]  : 4'h0;
         dia[j]   = (j == i) ? da[15:0] : 16'h0000;
         enb[j]   = (j == i) ? eb[0]    : 1'b0;
         web[j]   = (j == i) ? wb[1:0]  : 2'b00;
         addrb[j] = (j == i) ? ab[3:0]  : 4'h0;
         dib[j]   = (j == i) ? db[15:0] : 16'h0000;
         model_step(j, ena[j], wea[j], addra[j], dia[j], enb[j], web[j], addrb[j], dib[j]);
      end
      @(negedge clk);
      #1;
   endtask

   // Called just after rst is released: busy must stay high for exactly 16 cycles.
   task automatic sweep_check(input string tag);
      int n;
      n = 0;
      while (busy[0] && n < 40) begin
         n++;
         @(negedge clk);
      end
      #1;
      chk({tag, "_len"}, n, 16);
      chk({tag, "_busy1"}, 32'(busy[1]), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int j = 0; j < 2; j++) begin
         ena[j] = 1'b0; enb[j] = 1'b0; wea[j] = 2'b00; web[j] = 2'b00;
         addra[j] = 4'h0; addrb[j] = 4'h0; dia[j] = 16'h0000; dib[j] = 16'h0000;
      end
      repeat (2) @(negedge clk);
      #1;
      for (int j = 0; j < 2; j++) begin
         chk("rst_doa", 32'(doa[j]), 0);
         chk("rst_dob", 32'(dob[j]), 0);
         chk("rst_collision", 32'(collision[j]), 0);
         chk("rst_busy", 32'(busy[j]), 1);
      end
      rst = 1'b0;
      sweep_check("sweep");
      reset_model();

      // Fill both arrays with non-zero data so the next sweep has work to do.
      for (int a = 0; a < 16; a++) begin
         drive(0, 1, 3, a, 'h0100 + a*3 + 1, 1, 3, 15 - a, 'hF000 + a);
         drive(1, 1, 3, a, 'h0200 + a*5 + 7, 0, 0, 0, 0);
      end
      drive(0, 1, 0, 4, 0, 1, 0, 11, 0);
      drive(1, 1, 0, 4, 0, 1, 0, 11, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset mid-sweep restarts the full sweep.
      rst = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;
      repeat (7) @(negedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk); #1;
      chk("midrst_busy0", 32'(busy[0]), 1);
      chk("midrst_busy1", 32'(busy[1]), 1);
      rst = 1'b0;
      sweep_check("sweep_restart");
      reset_model();

      // Every address reads zero on both ports of both instances.
      for (int a = 0; a < 16; a++) begin
         drive(0, 1, 0, a, 0, 1, 0, 15 - a, 0);
         drive(1, 1, 0, a, 0, 1, 0, 15 - a, 0);
      end

      // ram0: byte write with write-first, read-first, collisions.
      drive(0, 1, 3, 3, 'h1234, 0, 0, 0, 0);
      drive(0, 1, 1, 3, 'hABCD, 0, 0, 0, 0);
      drive(0, 1, 0, 3, 0, 1, 0, 3, 0);
      drive(0, 0, 0, 0, 0, 1, 3, 7, 'hAAAA);
      drive(0, 0, 0, 0, 0, 1, 3, 7, 'h5555);
      drive(0, 1, 0, 7, 0, 1, 0, 7, 0);
      drive(0, 1, 3, 5, 'h1111, 1, 2, 5, 'h2222);
      drive(0, 1, 0, 5, 0, 0, 0, 0, 0);
      drive(0, 1, 2, 5, 'h1111, 1, 1, 5, 'h2222);
      drive(0, 1, 0, 5, 0, 1, 0, 5, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // ram1: no-change hold, output register latency, cross-port read.
      drive(1, 1, 3, 2, 'h0042, 0, 0, 0, 0);
      drive(1, 1, 3, 6, 'hAAAA, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 0, 2, 0);
      drive(1, 0, 0, 0, 0, 1, 3, 6, 'h5555);
      drive(1, 0, 0, 0, 0, 1, 0, 6, 0);
      drive(1, 1, 3, 9, 'h0009, 0, 0, 0, 0);
      drive(1, 1, 0, 9, 0, 1, 3, 9, 'h7777);
      drive(1, 1, 0, 9, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Mixed random traffic over a few addresses to provoke collisions.
      for (int k = 0; k < 80; k++) begin
         drive(int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
      end

      repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("sb_drain", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
